// File: rtl/dual_pulse_gen_pkg.sv
// Shared types for the dual pulse generator: controller state encoding and default field width.
// The DONE state exists only when DUAL_PULSE_GEN_BURST_EN is defined.
package dual_pulse_gen_pkg;

    localparam int CW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef DUAL_PULSE_GEN_BURST_EN
        , ST_DONE = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/dual_pulse_gen_pulse_channel.sv
// One counter/compare channel: counts 0..period-1 while running and drives a registered
// output that is high while the next count is below the high time.
module pulse_channel
    import dual_pulse_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic [CW-1:0] period_i,
    input  logic [CW-1:0] high_i,
    input  logic          force_low_i,
    output logic [CW-1:0] cnt_o,
    output logic          out_o
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // run_i and load_i describe the controller's next cycle, so out_q lines up with cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q == period_i - ONE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        out_d = run_i && !force_low_i && (cnt_d < high_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign cnt_o = cnt_q;
    assign out_o = out_q;

endmodule

// File: rtl/dual_pulse_gen.sv
// Two phase-related test waveforms (x, y) with a single-entry config shadow applied at period
// boundaries. Optional burst mode (cfg_burst, burst_done, DONE state) under DUAL_PULSE_GEN_BURST_EN.
module dual_pulse_gen
    import dual_pulse_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk200M,
    input  logic          rst,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_x_high,
    input  logic [CW-1:0] cfg_phase,
    input  logic [CW-1:0] cfg_y_high,
`ifdef DUAL_PULSE_GEN_BURST_EN
    input  logic [CW-1:0] cfg_burst,
    output logic          burst_done,
`endif
    output logic          x,
    output logic          y,
    output logic          period_tick,
    output logic          running
);

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    state_e        state_q, state_d;
    logic          sh_full_q, sh_full_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] sh_period_q, sh_xh_q, sh_ph_q, sh_yh_q;
    logic [CW-1:0] act_period_q, act_xh_q, act_ph_q, act_yh_q;

    logic          accept, apply, restart, boundary, run_nx;
    logic [CW-1:0] nx_period, nx_xh, nx_ph, nx_yh;
    logic          y_force_low;
    logic [CW-1:0] y_start;
    logic [CW-1:0] xcnt, ycnt_unused;

`ifdef DUAL_PULSE_GEN_BURST_EN
    logic [CW-1:0] sh_burst_q, act_burst_q;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          bdone_q, bdone_d;
`endif

    always_comb begin
        accept   = cfg_valid && !sh_full_q;
        boundary = (state_q == ST_RUN) && (xcnt == act_period_q - ONE);
        state_d  = state_q;
        apply    = 1'b0;
        restart  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending shadow is applied before leaving IDLE so RUN always starts on it.
                if (sh_full_q) begin
                    apply = 1'b1;
                end else if (enable && (act_period_q >= TWO)) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
`ifdef DUAL_PULSE_GEN_BURST_EN
                    end else if ((act_burst_q != '0) && (bcnt_q == act_burst_q - ONE)) begin
                        state_d = ST_DONE;
`endif
                    end else if (sh_full_q) begin
                        apply   = 1'b1;
                        restart = 1'b1;
                        if (sh_period_q < TWO) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
`ifdef DUAL_PULSE_GEN_BURST_EN
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        sh_full_d = sh_full_q;
        if (apply) begin
            sh_full_d = 1'b0;
        end else if (accept) begin
            sh_full_d = 1'b1;
        end

        nx_period   = apply ? sh_period_q : act_period_q;
        nx_xh       = apply ? sh_xh_q     : act_xh_q;
        nx_ph       = apply ? sh_ph_q     : act_ph_q;
        nx_yh       = apply ? sh_yh_q     : act_yh_q;
        y_force_low = (nx_ph >= nx_period);
        // y leads by (period - phase) so its rising edge trails x by exactly phase clocks.
        y_start     = (y_force_low || (nx_ph == '0)) ? '0 : (nx_period - nx_ph);

        run_nx = (state_d == ST_RUN);
        tick_d = run_nx && ((state_q != ST_RUN) || boundary);
    end

    always_ff @(posedge clk200M or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sh_full_q    <= 1'b0;
            tick_q       <= 1'b0;
            sh_period_q  <= '0;
            sh_xh_q      <= '0;
            sh_ph_q      <= '0;
            sh_yh_q      <= '0;
            act_period_q <= '0;
            act_xh_q     <= '0;
            act_ph_q     <= '0;
            act_yh_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_full_q <= sh_full_d;
            tick_q    <= tick_d;
            if (accept) begin
                sh_period_q <= (cfg_period == ONE) ? TWO : cfg_period;
                sh_xh_q     <= cfg_x_high;
                sh_ph_q     <= cfg_phase;
                sh_yh_q     <= cfg_y_high;
            end
            if (apply) begin
                act_period_q <= sh_period_q;
                act_xh_q     <= sh_xh_q;
                act_ph_q     <= sh_ph_q;
                act_yh_q     <= sh_yh_q;
            end
        end
    end

`ifdef DUAL_PULSE_GEN_BURST_EN
    always_comb begin
        bcnt_d = bcnt_q;
        if (restart) begin
            bcnt_d = '0;
        end else if (boundary && run_nx) begin
            bcnt_d = bcnt_q + ONE;
        end
        bdone_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk200M or posedge rst) begin
        if (rst) begin
            sh_burst_q  <= '0;
            act_burst_q <= '0;
            bcnt_q      <= '0;
            bdone_q     <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            bdone_q <= bdone_d;
            if (accept) begin
                sh_burst_q <= cfg_burst;
            end
            if (apply) begin
                act_burst_q <= sh_burst_q;
            end
        end
    end

    assign burst_done = bdone_q;
`endif

    pulse_channel #(.CW(CW)) u_x (
        .clk_i       (clk200M),
        .rst_i       (rst),
        .run_i       (run_nx),
        .load_i      (restart),
        .load_val_i  ('0),
        .period_i    (nx_period),
        .high_i      (nx_xh),
        .force_low_i (1'b0),
        .cnt_o       (xcnt),
        .out_o       (x)
    );

    pulse_channel #(.CW(CW)) u_y (
        .clk_i       (clk200M),
        .rst_i       (rst),
        .run_i       (run_nx),
        .load_i      (restart),
        .load_val_i  (y_start),
        .period_i    (nx_period),
        .high_i      (nx_yh),
        .force_low_i (y_force_low),
        .cnt_o       (ycnt_unused),
        .out_o       (y)
    );

    assign cfg_ready   = !sh_full_q;
    assign running     = (state_q == ST_RUN);
    assign period_tick = tick_q;

endmodule

// File: tb/tb_dual_pulse_gen.sv
// Directed bench for dual_pulse_gen: table of configurations with hand-derived per-period
// x/y patterns, plus sequences for reconfiguration, enable drop, reset and burst mode.
module tb_dual_pulse_gen;

    localparam int CW = 32;

    logic          clk200M = 1'b0;
    logic          rst, enable, cfg_valid, cfg_ready;
    logic [CW-1:0] cfg_period, cfg_x_high, cfg_phase, cfg_y_high;
    logic          x, y, period_tick, running;
`ifdef DUAL_PULSE_GEN_BURST_EN
    logic [CW-1:0] cfg_burst;
    logic          burst_done;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          p_in;
        int          eff_p;
        int          xh;
        int          ph;
        int          yh;
        logic [31:0] xpat;
        logic [31:0] ypat;
    } vec_t;

    vec_t vecs[6];

    dual_pulse_gen #(.CW(CW)) dut (
        .clk200M     (clk200M),
        .rst         (rst),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_x_high  (cfg_x_high),
        .cfg_phase   (cfg_phase),
        .cfg_y_high  (cfg_y_high),
`ifdef DUAL_PULSE_GEN_BURST_EN
        .cfg_burst   (cfg_burst),
        .burst_done  (burst_done),
`endif
        .x           (x),
        .y           (y),
        .period_tick (period_tick),
        .running     (running)
    );

    always #5 clk200M = ~clk200M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk200M);
        #1;
    endtask

    function automatic logic bitof(logic [31:0] v, int i);
        return v[i[4:0]];
    endfunction

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic cfg_send(int p, int xh, int ph, int yh);
        logic hs;
        hs         = 1'b0;
        cfg_period = p;
        cfg_x_high = xh;
        cfg_phase  = ph;
        cfg_y_high = yh;
        cfg_valid  = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            hs = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        chk("cfg_handshake", hs, 1'b1);
    endtask

    task automatic wait_run(string name);
        logic r;
        r = 1'b0;
        for (int n = 0; n < 20 && !r; n++) begin
            if (running) r = 1'b1;
            else tick();
        end
        chk(name, r, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_x_high = '0;
        cfg_phase  = '0;
        cfg_y_high = '0;
`ifdef DUAL_PULSE_GEN_BURST_EN
        cfg_burst  = '0;
`endif
        //               p_in eff  xh  ph  yh  x pattern   y pattern
        vecs[0] = '{10, 10,  3,  5,  5, 32'h007, 32'h3E0};
        vecs[1] = '{10, 10,  0,  0,  4, 32'h000, 32'h00F};
        vecs[2] = '{10, 10, 12, 10,  5, 32'h3FF, 32'h000};
        vecs[3] = '{ 8,  8,  4,  2,  3, 32'h00F, 32'h01C};
        vecs[4] = '{ 1,  2,  1,  0,  1, 32'h001, 32'h001};
        vecs[5] = '{ 6,  6,  6,  5,  2, 32'h03F, 32'h021};

        for (int k = 0; k < 6; k++) begin
            do_reset();
            chk($sformatf("v%0d_rst_ready", k), cfg_ready, 1'b1);
            chk($sformatf("v%0d_rst_run", k), running, 1'b0);
            chk($sformatf("v%0d_rst_x", k), x, 1'b0);
            chk($sformatf("v%0d_rst_y", k), y, 1'b0);
            cfg_send(vecs[k].p_in, vecs[k].xh, vecs[k].ph, vecs[k].yh);
            enable = 1'b1;
            wait_run($sformatf("v%0d_start", k));
            for (int i = 0; i < 2 * vecs[k].eff_p; i++) begin
                chk($sformatf("v%0d_x_c%0d", k, i), x, bitof(vecs[k].xpat, i % vecs[k].eff_p));
                chk($sformatf("v%0d_y_c%0d", k, i), y, bitof(vecs[k].ypat, i % vecs[k].eff_p));
                chk($sformatf("v%0d_tick_c%0d", k, i), period_tick, (i % vecs[k].eff_p) == 0);
                chk($sformatf("v%0d_run_c%0d", k, i), running, 1'b1);
                tick();
            end
            chk($sformatf("v%0d_tick_wrap", k), period_tick, 1'b1);
        end

        // Mid-run reconfiguration, then a handshake landing on a boundary cycle.
        do_reset();
        cfg_send(10, 3, 5, 5);
        enable = 1'b1;
        wait_run("A_start");
        tick(); tick(); tick();
        cfg_period = 20; cfg_x_high = 10; cfg_phase = 0; cfg_y_high = 10;
        cfg_valid  = 1'b1;
        chk("A_ready_before", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        for (int i = 4; i < 10; i++) begin
            chk($sformatf("A_old_x_c%0d", i), x, bitof(32'h007, i));
            chk($sformatf("A_old_y_c%0d", i), y, bitof(32'h3E0, i));
            chk($sformatf("A_ready_low_c%0d", i), cfg_ready, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("A_new_x_c%0d", i), x, i < 10);
            chk($sformatf("A_new_y_c%0d", i), y, i < 10);
            chk($sformatf("A_new_tick_c%0d", i), period_tick, i == 0);
            chk($sformatf("A_new_ready_c%0d", i), cfg_ready, 1'b1);
            if (i == 19) begin
                cfg_period = 10; cfg_x_high = 3; cfg_phase = 5; cfg_y_high = 5;
                cfg_valid  = 1'b1;
            end
            tick();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("A_late_x_c%0d", i), x, i < 10);
            chk($sformatf("A_late_tick_c%0d", i), period_tick, i == 0);
            chk($sformatf("A_late_ready_c%0d", i), cfg_ready, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("A_back_x_c%0d", i), x, bitof(32'h007, i));
            chk($sformatf("A_back_y_c%0d", i), y, bitof(32'h3E0, i));
            chk($sformatf("A_back_tick_c%0d", i), period_tick, i == 0);
            tick();
        end
        chk("A_back_tick_wrap", period_tick, 1'b1);

        // Enable dropped and restored within a period, then dropped for good at xcnt=4.
        do_reset();
        cfg_send(10, 3, 5, 5);
        enable = 1'b1;
        wait_run("B_start");
        tick(); tick(); tick(); tick();
        enable = 1'b0;
        tick(); tick(); tick();
        enable = 1'b1;
        tick(); tick(); tick();
        chk("B_seamless_run", running, 1'b1);
        chk("B_seamless_tick", period_tick, 1'b1);
        chk("B_seamless_x", x, 1'b1);
        tick(); tick(); tick(); tick();
        enable = 1'b0;
        for (int i = 5; i < 10; i++) begin
            tick();
            chk($sformatf("B_tail_run_c%0d", i), running, 1'b1);
            chk($sformatf("B_tail_x_c%0d", i), x, bitof(32'h007, i));
            chk($sformatf("B_tail_y_c%0d", i), y, bitof(32'h3E0, i));
        end
        tick();
        chk("B_idle_run", running, 1'b0);
        chk("B_idle_x", x, 1'b0);
        chk("B_idle_y", y, 1'b0);
        chk("B_idle_tick", period_tick, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("B_stay_idle_%0d", i), running | x | y | period_tick, 1'b0);
        end

        // Asynchronous reset at xcnt=6, then no activity until a valid config is reloaded.
        do_reset();
        cfg_send(10, 3, 5, 5);
        enable = 1'b1;
        wait_run("C_start");
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("C_pre_y", y, 1'b1);
        chk("C_pre_run", running, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("C_async_x", x, 1'b0);
        chk("C_async_y", y, 1'b0);
        chk("C_async_run", running, 1'b0);
        chk("C_async_ready", cfg_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk($sformatf("C_quiet_%0d", i), running | x | y | period_tick, 1'b0);
        end
        cfg_send(0, 3, 5, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("C_p0_idle_%0d", i), running | x | y | period_tick, 1'b0);
        end
        cfg_send(10, 3, 5, 5);
        wait_run("C_rerun");
        chk("C_rerun_x", x, 1'b1);
        chk("C_rerun_tick", period_tick, 1'b1);

`ifdef DUAL_PULSE_GEN_BURST_EN
        // Burst of 4 periods: DONE entered on cycle 40 with a single burst_done pulse.
        begin
            int   pulses;
            logic prev_x;
            do_reset();
            cfg_burst = 4;
            cfg_send(10, 3, 5, 5);
            enable = 1'b1;
            wait_run("D_start");
            pulses = 0;
            prev_x = 1'b0;
            for (int i = 0; i < 60; i++) begin
                chk($sformatf("D_x_c%0d", i), x, (i < 40) ? bitof(32'h007, i % 10) : 1'b0);
                chk($sformatf("D_done_c%0d", i), burst_done, i == 40);
                chk($sformatf("D_run_c%0d", i), running, i < 40);
                if (x && !prev_x) pulses++;
                prev_x = x;
                tick();
            end
            chk("D_pulse_count", pulses == 4, 1'b1);
            enable = 1'b0;
            tick();
            tick();
            chk("D_idle_run", running, 1'b0);
            chk("D_idle_done", burst_done, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
